// File: rtl/spi_byte_sequencer.sv
// -----------------------------------------------------------------------------
// spi_byte_sequencer
//
// Byte-level controller for an SPI slave shift register. Frames transactions on
// chip select, counts oversampled sclk falling edges to delimit bytes, loads the
// next transmit byte into the shift register at byte start and hands the
// received byte to the host at byte end.
//
// Ports
//   writeClk   system clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   sclk, csN  raw SPI clock (CPOL=0) and active-low chip select
//   srPOut     shift register parallel output (received byte)
//   srWriteP   shift register parallel-load strobe (one cycle per byte)
//   srPIn      shift register parallel-load data
//   srResetN   shift register active-low reset (low while idle)
//   txData/txValid/txReady   transmit byte handshake (txReady = consumed)
//   rxData/rxValid/rxReady   receive byte handshake (rxValid = updated)
//   rxOverrun  sticky: a byte completed while rxReady was low
//   aborted    pulse: chip select released mid-byte
//   busy       high whenever the sequencer is not idle
//   byteCount  bytes completed in the current transaction (wraps)
// -----------------------------------------------------------------------------
module spi_byte_sequencer #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF,
  parameter int         CNT_W     = 8
) (
  input  logic             writeClk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             csN,
  input  logic [7:0]       srPOut,
  output logic             srWriteP,
  output logic [7:0]       srPIn,
  output logic             srResetN,
  input  logic [7:0]       txData,
  input  logic             txValid,
  output logic             txReady,
  output logic [7:0]       rxData,
  output logic             rxValid,
  input  logic             rxReady,
  output logic             rxOverrun,
  output logic             aborted,
  output logic             busy,
  output logic [CNT_W-1:0] byteCount
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  // Synchronizer chains: [0] first flop, [1] synchronized value, [2] previous.
  logic [2:0] cs_sync_reg;
  logic [2:0] sclk_sync_reg;
  logic       cs_s;

  // Edge detects are registered so every FSM input comes straight from a flop.
  logic cs_fall_reg, cs_rise_reg, sclk_fall_reg;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;

  logic             wp_reg, wp_next;
  logic [7:0]       pin_reg, pin_next;
  logic             srn_reg, srn_next;
  logic             txr_reg, txr_next;
  logic [7:0]       rxd_reg, rxd_next;
  logic             rxv_reg, rxv_next;
  logic             ovr_reg, ovr_next;
  logic             abort_reg, abort_next;
  logic             busy_reg, busy_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign cs_s = cs_sync_reg[1];

  always_ff @(posedge writeClk) begin
    if (reset) begin
      cs_sync_reg   <= 3'b111;
      sclk_sync_reg <= 3'b000;
      cs_fall_reg   <= 1'b0;
      cs_rise_reg   <= 1'b0;
      sclk_fall_reg <= 1'b0;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[1:0], csN};
      sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
      cs_fall_reg   <= cs_sync_reg[2] & ~cs_sync_reg[1];
      cs_rise_reg   <= ~cs_sync_reg[2] & cs_sync_reg[1];
      sclk_fall_reg <= sclk_sync_reg[2] & ~sclk_sync_reg[1];
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    wp_next      = 1'b0;
    txr_next     = 1'b0;
    rxv_next     = 1'b0;
    abort_next   = 1'b0;
    pin_next     = pin_reg;
    rxd_next     = rxd_reg;
    ovr_next     = ovr_reg;
    cnt_next     = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (cs_fall_reg) begin
          state_next = LOAD;
          cnt_next   = '0;
          ovr_next   = 1'b0;
        end
      end
      LOAD: begin
        state_next   = SHIFT;
        bit_cnt_next = 3'd0;
      end
      SHIFT: begin
        // A chip-select release beats a simultaneous final sclk edge.
        if (cs_rise_reg) begin
          state_next = IDLE;
          abort_next = 1'b1;
        end else if (sclk_fall_reg) begin
          if (bit_cnt_reg == 3'd7) begin
            state_next = DONE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      DONE: begin
        state_next = (cs_s || cs_rise_reg) ? IDLE : LOAD;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    // and appear in the same cycle the FSM occupies that state.
    case (state_next)
      LOAD: begin
        wp_next  = 1'b1;
        pin_next = txValid ? txData : IDLE_BYTE;
        txr_next = txValid;
      end
      DONE: begin
        rxv_next = 1'b1;
        rxd_next = srPOut;
        cnt_next = cnt_reg + CNT_W'(1);
        if (!rxReady) begin
          ovr_next = 1'b1;
        end
      end
      default: ;
    endcase

    busy_next = (state_next != IDLE);
    srn_next  = (state_next != IDLE);
  end

  always_ff @(posedge writeClk) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      wp_reg      <= 1'b0;
      pin_reg     <= 8'h00;
      srn_reg     <= 1'b0;
      txr_reg     <= 1'b0;
      rxd_reg     <= 8'h00;
      rxv_reg     <= 1'b0;
      ovr_reg     <= 1'b0;
      abort_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      wp_reg      <= wp_next;
      pin_reg     <= pin_next;
      srn_reg     <= srn_next;
      txr_reg     <= txr_next;
      rxd_reg     <= rxd_next;
      rxv_reg     <= rxv_next;
      ovr_reg     <= ovr_next;
      abort_reg   <= abort_next;
      busy_reg    <= busy_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign srWriteP  = wp_reg;
  assign srPIn     = pin_reg;
  assign srResetN  = srn_reg;
  assign txReady   = txr_reg;
  assign rxData    = rxd_reg;
  assign rxValid   = rxv_reg;
  assign rxOverrun = ovr_reg;
  assign aborted   = abort_reg;
  assign busy      = busy_reg;
  assign byteCount = cnt_reg;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_sequencer
//
// Drives SPI transactions with randomized phase lengths and data. Each stimulus
// step schedules the events it implies (load, byte delivery, abort, idle) at
// the cycle the latency rules put them, and one compare process checks every
// output on every cycle against that schedule. Directed literal checks pin the
// schedule itself.
// -----------------------------------------------------------------------------
module tb_spi_byte_sequencer;

  localparam int CNT_W = 2;
  localparam int MAXC  = 32768;

  logic             writeClk = 1'b0;
  logic             reset    = 1'b1;
  logic             sclk     = 1'b0;
  logic             csN      = 1'b1;
  logic [7:0]       srPOut   = 8'h00;
  logic             srWriteP;
  logic [7:0]       srPIn;
  logic             srResetN;
  logic [7:0]       txData   = 8'h00;
  logic             txValid  = 1'b0;
  logic             txReady;
  logic [7:0]       rxData;
  logic             rxValid;
  logic             rxReady  = 1'b1;
  logic             rxOverrun;
  logic             aborted;
  logic             busy;
  logic [CNT_W-1:0] byteCount;

  spi_byte_sequencer #(.IDLE_BYTE(8'hFF), .CNT_W(CNT_W)) dut (
    .writeClk (writeClk),
    .reset    (reset),
    .sclk     (sclk),
    .csN      (csN),
    .srPOut   (srPOut),
    .srWriteP (srWriteP),
    .srPIn    (srPIn),
    .srResetN (srResetN),
    .txData   (txData),
    .txValid  (txValid),
    .txReady  (txReady),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .rxReady  (rxReady),
    .rxOverrun(rxOverrun),
    .aborted  (aborted),
    .busy     (busy),
    .byteCount(byteCount)
  );

  always #5 writeClk = ~writeClk;

  // cyc = number of rising edges so far; "cycle c" is the interval after edge c.
  int cyc = 0;
  always @(posedge writeClk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Event schedule, indexed by cycle.
  bit       exp_rst     [MAXC];
  bit       exp_wp      [MAXC];
  logic [7:0] exp_pin   [MAXC];
  bit       exp_txr     [MAXC];
  bit       exp_first   [MAXC];
  bit       exp_busy_on [MAXC];
  bit       exp_busy_off[MAXC];
  bit       exp_rxv     [MAXC];
  logic [7:0] exp_rxd   [MAXC];
  bit       exp_ovr     [MAXC];
  bit       exp_abort   [MAXC];

  // Model state derived from the schedule.
  int         m_bc   = 0;
  bit         m_ovr  = 0;
  bit         m_busy = 0;
  logic [7:0] m_rxd  = 8'h00;
  logic [7:0] m_pin  = 8'h00;

  int n_abort_seen = 0;
  int bc_seq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge writeClk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (exp_rst[cyc]) begin
        m_bc = 0; m_ovr = 0; m_busy = 0; m_rxd = 8'h00; m_pin = 8'h00;
      end
      if (exp_first[cyc])    begin m_bc = 0; m_ovr = 0; end
      if (exp_busy_on[cyc])  m_busy = 1;
      if (exp_busy_off[cyc]) m_busy = 0;
      if (exp_wp[cyc])       m_pin = exp_pin[cyc];
      if (exp_rxv[cyc]) begin
        m_rxd = exp_rxd[cyc];
        m_bc  = (m_bc + 1) % (1 << CNT_W);
        if (exp_ovr[cyc]) m_ovr = 1;
      end
      chk("srWriteP",  srWriteP,  exp_wp[cyc]);
      chk("srPIn",     srPIn,     m_pin);
      chk("txReady",   txReady,   exp_txr[cyc]);
      chk("rxValid",   rxValid,   exp_rxv[cyc]);
      chk("rxData",    rxData,    m_rxd);
      chk("rxOverrun", rxOverrun, m_ovr);
      chk("aborted",   aborted,   exp_abort[cyc]);
      chk("busy",      busy,      m_busy);
      chk("srResetN",  srResetN,  m_busy);
      chk("byteCount", byteCount, m_bc);
      if (aborted === 1'b1) n_abort_seen++;
      if (rxValid === 1'b1) bc_seq.push_back(int'(byteCount));
    end
  end

  always @(negedge writeClk) begin
    if (cyc >= MAXC - 10) begin
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "cycle budget exhausted");
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge writeClk);
  endtask

  function automatic bit pick(input int mode);
    if (mode == 2) return bit'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic schedule_load(input int c, input bit v, input logic [7:0] d, input bit first);
    exp_wp[c]  = 1'b1;
    exp_pin[c] = v ? d : 8'hFF;
    exp_txr[c] = v;
    if (first) begin
      exp_first[c]   = 1'b1;
      exp_busy_on[c] = 1'b1;
    end
  endtask

  // nbytes: bytes started; abort_at>0: csN rises after that many falls of the
  // last byte; simul: csN rises together with the last byte's 8th fall.
  // mode 0 = never, 1 = always, 2 = random. tx0/rx0 >= 0 force byte 0 data.
  int txn_id = 0;
  task automatic run_txn(input int nbytes, input int abort_at, input bit simul,
                         input int txv_mode, input int rxr_mode,
                         input int tx0, input int rx0);
    bit cur_txv, nxt_txv, rxr, last;
    logic [7:0] cur_txd, nxt_txd, rxd;
    int n, m, r;
    txn_id++;
    $display("txn %0d: bytes=%0d abort_at=%0d simul=%0d txv_mode=%0d rxr_mode=%0d",
             txn_id, nbytes, abort_at, simul, txv_mode, rxr_mode);
    cur_txv = (tx0 >= 0) ? 1'b1 : pick(txv_mode);
    cur_txd = (tx0 >= 0) ? tx0[7:0] : 8'($urandom);
    txValid = cur_txv;
    txData  = cur_txd;
    @(negedge writeClk);
    csN = 1'b0;
    n = cyc;
    schedule_load(n + 4, cur_txv, cur_txd, 1'b1);
    tick(4);
    if (tx0 >= 0) begin
      chk("lit_srWriteP", srWriteP, 1);
      chk("lit_txReady",  txReady,  1);
      chk("lit_srPIn",    srPIn,    tx0);
    end
    tick(2 + $urandom_range(0, 3));
    for (int b = 0; b < nbytes; b++) begin
      last = (b == nbytes - 1);
      for (int i = 1; i <= 8; i++) begin
        sclk = 1'b1;
        if (i == 1) begin
          rxr = pick(rxr_mode);
          rxd = (rx0 >= 0 && b == 0) ? rx0[7:0] : 8'($urandom);
          rxReady = rxr;
          srPOut  = rxd;
          nxt_txv = pick(txv_mode);
          nxt_txd = 8'($urandom);
          txValid = nxt_txv;
          txData  = nxt_txd;
        end
        tick(4 + $urandom_range(0, 2));
        sclk = 1'b0;
        m = cyc;
        if (last && i == 8 && simul) begin
          csN = 1'b1;
          exp_abort[m + 4]    = 1'b1;
          exp_busy_off[m + 4] = 1'b1;
          tick(10);
          return;
        end
        if (i == 8) begin
          exp_rxv[m + 4] = 1'b1;
          exp_rxd[m + 4] = rxd;
          exp_ovr[m + 4] = !rxr;
          if (last) begin
            tick(1 + $urandom_range(0, 1));
            csN = 1'b1;
            exp_busy_off[m + 5] = 1'b1;
            tick(10);
            return;
          end
          schedule_load(m + 5, nxt_txv, nxt_txd, 1'b0);
        end else if (last && i == abort_at) begin
          tick(1 + $urandom_range(0, 1));
          csN = 1'b1;
          r = cyc;
          exp_abort[r + 4]    = 1'b1;
          exp_busy_off[r + 4] = 1'b1;
          tick(10);
          return;
        end
        tick(5 + $urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    int ab0;
    int n;
    int want_seq[5];
    want_seq = '{1, 2, 3, 0, 1};
    exp_rst[1] = 1'b1;
    exp_rst[2] = 1'b1;
    exp_rst[3] = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(4);

    // Single byte, known data.
    run_txn(1, 0, 0, 1, 1, 'hA5, 'h3C);
    chk("t1_rxData",    rxData,    8'h3C);
    chk("t1_byteCount", byteCount, 1);

    // Three bytes, nothing to transmit.
    run_txn(3, 0, 0, 0, 1, -1, -1);
    chk("t2_byteCount", byteCount, 3);
    chk("t2_busy",      busy,      0);

    // Abort after 5 falls.
    ab0 = n_abort_seen;
    run_txn(1, 5, 0, 1, 1, -1, -1);
    chk("t3_aborts",    n_abort_seen - ab0, 1);
    chk("t3_byteCount", byteCount, 0);
    chk("t3_srResetN",  srResetN,  0);
    chk("t3_busy",      busy,      0);

    // Host never ready: overrun stays set.
    run_txn(2, 0, 0, 2, 0, -1, -1);
    chk("t4_overrun", rxOverrun, 1);

    // Five bytes with a 2-bit counter: wraps.
    bc_seq.delete();
    run_txn(5, 0, 0, 2, 1, -1, -1);
    chk("t5_count", bc_seq.size(), 5);
    for (int i = 0; i < 5 && i < bc_seq.size(); i++)
      chk("t5_seq", bc_seq[i], want_seq[i]);
    chk("t5_overrun", rxOverrun, 0);

    // csN rises on the same sampled edge as the 8th fall of byte 2.
    ab0 = n_abort_seen;
    run_txn(2, 0, 1, 2, 1, -1, -1);
    chk("t6_aborts",    n_abort_seen - ab0, 1);
    chk("t6_byteCount", byteCount, 1);

    // Reset after 4 falls, then a normal transaction.
    $display("txn reset_mid: 4 falls then reset");
    txValid = 1'b1;
    txData  = 8'($urandom);
    @(negedge writeClk);
    csN = 1'b0;
    n = cyc;
    schedule_load(n + 4, 1'b1, txData, 1'b1);
    tick(7);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1; tick(4);
      sclk = 1'b0; tick(4);
    end
    reset = 1'b1;
    csN   = 1'b1;
    exp_rst[cyc + 1] = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t7_busy",      busy,      0);
    chk("t7_srResetN",  srResetN,  0);
    chk("t7_srPIn",     srPIn,     0);
    chk("t7_rxData",    rxData,    0);
    chk("t7_byteCount", byteCount, 0);
    tick(6);
    run_txn(2, 0, 0, 2, 2, -1, -1);

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      int nb, abt;
      bit sim;
      nb  = $urandom_range(1, 4);
      abt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      sim = (abt == 0) && ($urandom_range(0, 5) == 0);
      run_txn(nb, abt, sim, 2, 2, -1, -1);
      tick($urandom_range(0, 5));
    end

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
